link_delay_arbiter: RTL and testbench
=====================================

// Module: link_delay_arbiter
// PURPOSE
//  Shares one fixed-latency emulated NoC link between NUM_REQ local requesters.
//  A round-robin arbiter grants one requester and latches its flit. After
//  DELAY cycles it presents the flit on data_out and pulses that requester's ack.
//  Sits between router output ports and the link model.
//  Sequences the delay counter so only one flit is in flight at a time.
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  DATA_W   16  flit width in bits
//  DELAY    36  grant-to-delivery latency in cycles (>=1)
//  CNT_W    6   delay counter width; must satisfy 2**CNT_W > DELAY
// PORTS
//  clk        in   1                single clock, rising edge
//  reset      in   1                asynchronous, active-high
//  req        in   NUM_REQ          per-requester request, level
//  data_in    in   NUM_REQ*DATA_W   flit of requester i at [i*DATA_W +: DATA_W]
//  ack        out  NUM_REQ          one-hot, 1-cycle pulse: flit delivered
//  data_out   out  DATA_W           delivered flit; holds until next delivery
//  out_valid  out  1                1-cycle pulse, coincident with ack
//  busy       out  1                high from grant until delivery (inclusive)
//  grant_id   out  $clog2(NUM_REQ)  index of current/last granted requester
// BEHAVIOUR
//  Reset values (asserted asynchronously, held while reset=1):
//   - data_out=0, ack=0, out_valid=0, busy=0, grant_id=0
//   - rr_ptr=0, cnt=0, state=IDLE
//  FSM states: IDLE, HOLD, DONE. All outputs are registered.
//  IDLE:
//   - Samples req on each edge. If req != 0 at edge E, grants the first set bit
//     searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ... mod NUM_REQ).
//   - At E: latch data_in slice and grant_id, busy<=1, cnt<=1, rr_ptr<=grant+1
//     (mod NUM_REQ), state<=HOLD.
//   - If req == 0: stay in IDLE with no output change.
//  HOLD:
//   - cnt increments each edge. At edge E+DELAY: data_out<=latched flit,
//     out_valid<=1, ack[grant_id]<=1, state<=DONE.
//   - With DELAY=1, this occurs on the first edge after the grant.
//  DONE (one cycle):
//   - out_valid, ack and busy are driven 0 at the next edge; state<=IDLE.
//   - Arbitration does not occur in DONE.
//   - Earliest next grant is edge E+DELAY+2. Per-flit period is DELAY+2 cycles.
//  Requester contract:
//   - Holds req=1 and data_in stable until it sees ack.
//   - Drops req on the edge after ack, or keeps it high to request a new flit.
//   - This block samples data_in only at the grant edge.
//  req deasserted during HOLD: ignored; the flit is still delivered and acked.
//  Simultaneous requests: resolved purely by rr_ptr. Starvation-free; a
//   continuously requesting port waits at most NUM_REQ-1 grants.
//  Reset mid-operation: the flit is dropped; no ack or out_valid is issued.
//   All state returns to reset values.
//  cnt never wraps: it stops at DELAY, and CNT_W is sized so that 2**CNT_W > DELAY.
//  busy is the OR of (state==HOLD) and (state==DONE).
// TESTING
//  1 Assert reset mid-run, then release -> all outputs 0, rr_ptr 0; the first
//    grant goes to the lowest-index active req.
//  2 DELAY=36: req[0]=1, data 0xABCD sampled at edge 10 -> busy=1 at 10.
//    out_valid, ack=4'b0001, data_out=0xABCD at edge 46.
//    busy=0 at edge 47; data_out stays 0xABCD.
//  3 req=4'b1111 held continuously from edge 5 -> grants 0,1,2,3,0 at edges
//    5,43,81,119,157; deliveries 36 cycles after each grant.
//  4 req[0] and req[2] held continuously -> grant order 0,2,0,2; req[1] and
//    req[3] are never acked.
//  5 Grant req[1] at edge 10; assert reset at edge 25 -> no ack ever for that
//    flit. After release, req[1] is regranted and delivered DELAY cycles later.
//  6 DELAY=1 instance: req[3] granted at edge E -> ack[3] and out_valid at E+1.
//    The next grant happens at E+3.

Source files
------------

// File: rtl/link_delay_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : link_delay_arbiter_if
// Purpose  : Requester-side bundle for link_delay_arbiter: per-requester
//            request/flit inputs plus the delivery, busy and grant outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface link_delay_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] data_in;
   logic [NUM_REQ-1:0]        ack;
   logic [DATA_W-1:0]         data_out;
   logic                      out_valid;
   logic                      busy;
   logic [ID_W-1:0]           grant_id;

   // Requesters / link model side
   modport master (
      output req, data_in,
      input  ack, data_out, out_valid, busy, grant_id
   );

   // Arbiter side
   modport slave (
      input  req, data_in,
      output ack, data_out, out_valid, busy, grant_id
   );
endinterface
`default_nettype wire

// File: rtl/link_delay_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : link_delay_arbiter
// Purpose  : Round-robin arbitration of NUM_REQ requesters onto one emulated
//            fixed-latency link. One flit in flight at a time; the flit is
//            delivered DELAY cycles after its grant together with an ack pulse.
// Revision : 1.0 - initial release
// ============================================================================
module link_delay_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16,
   parameter int DELAY   = 36,
   parameter int CNT_W   = 6
) (
   input  wire logic           clk,
   input  wire logic           reset,
   link_delay_arbiter_if.slave bus
);
   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     grant_q, grant_d;
   logic [DATA_W-1:0]   flit_q, flit_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;

   logic [NUM_REQ-1:0]  hi_mask;
   logic [NUM_REQ-1:0]  req_hi;
   logic [NUM_REQ-1:0]  req_src;
   logic [ID_W-1:0]     pick_idx;
   logic [DATA_W-1:0]   pick_data;
   logic [NUM_REQ-1:0]  grant_onehot;

   // Round-robin pick: prefer requests at or above rr_ptr, else wrap to the
   // lowest set request; this is the upward search with wrap-around.
   always_comb begin
      hi_mask   = '0;
      pick_idx  = '0;
      pick_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         hi_mask[i] = (ID_W'(i) >= rr_ptr_q);
      end
      req_hi  = bus.req & hi_mask;
      req_src = (req_hi != '0) ? req_hi : bus.req;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_src[i]) begin
            pick_idx = ID_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == ID_W'(i)) begin
            pick_data = bus.data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   // Decode the latched grant into the one-hot ack pattern.
   always_comb begin
      grant_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_onehot[i] = (grant_q == ID_W'(i));
      end
   end

   // Next-state and registered-output logic for the grant/hold/deliver cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      flit_d      = flit_q;
      data_out_d  = data_out_q;
      ack_d       = ack_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req != '0) begin
               grant_d  = pick_idx;
               flit_d   = pick_data;
               busy_d   = 1'b1;
               cnt_d    = CNT_W'(1);
               rr_ptr_d = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
               state_d  = S_HOLD;
            end
         end
         S_HOLD: begin
            // cnt holds the number of edges since the grant; delivery lands
            // exactly DELAY edges after it, so cnt never passes DELAY.
            if (cnt_q == CNT_W'(DELAY)) begin
               data_out_d  = flit_q;
               out_valid_d = 1'b1;
               ack_d       = grant_onehot;
               state_d     = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            out_valid_d = 1'b0;
            ack_d       = '0;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any flit in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         flit_q      <= '0;
         data_out_q  <= '0;
         ack_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         flit_q      <= flit_d;
         data_out_q  <= data_out_d;
         ack_q       <= ack_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.ack       = ack_q;
   assign bus.data_out  = data_out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.grant_id  = grant_q;
endmodule
`default_nettype wire

// File: tb/tb_link_delay_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_delay_arbiter
// Purpose  : Scoreboard bench for link_delay_arbiter, DELAY=36 and DELAY=1
//            instances side by side, driven by randomized requesters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_delay_arbiter;
   localparam int N = 4;
   localparam int W = 16;

   typedef struct {
      int         id;
      logic [W-1:0] data;
      int         when;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]   req_v  [2];
   logic [N*W-1:0] din_v  [2];
   logic [N-1:0]   ack_w  [2];
   logic [W-1:0]   dout_w [2];
   logic           ov_w   [2];
   logic           busy_w [2];
   logic [1:0]     gid_w  [2];

   link_delay_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) if_a ();
   link_delay_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) if_b ();

   assign if_a.req     = req_v[0];
   assign if_a.data_in = din_v[0];
   assign if_b.req     = req_v[1];
   assign if_b.data_in = din_v[1];
   assign ack_w[0]  = if_a.ack;       assign ack_w[1]  = if_b.ack;
   assign dout_w[0] = if_a.data_out;  assign dout_w[1] = if_b.data_out;
   assign ov_w[0]   = if_a.out_valid; assign ov_w[1]   = if_b.out_valid;
   assign busy_w[0] = if_a.busy;      assign busy_w[1] = if_b.busy;
   assign gid_w[0]  = if_a.grant_id;  assign gid_w[1]  = if_b.grant_id;

   link_delay_arbiter #(.NUM_REQ(N), .DATA_W(W), .DELAY(36), .CNT_W(6)) u_d36 (
      .clk(clk), .reset(rst), .bus(if_a.slave));
   link_delay_arbiter #(.NUM_REQ(N), .DATA_W(W), .DELAY(1), .CNT_W(1)) u_d1 (
      .clk(clk), .reset(rst), .bus(if_b.slave));

   function automatic int dly(int d);
      return (d == 0) ? 36 : 1;
   endfunction

   exp_t sb [2][$];
   int edge_n = 0;
   int rr_m [2];
   int free_m [2];
   int gedge_m [2];
   int gid_m [2];
   logic [W-1:0] last_m [2];
   int n_cmp = 0;
   int n_bad = 0;

   logic [N-1:0] mask = '0;
   int p_raise = 0;
   int p_keep  = 0;
   logic fixed = 1'b0;

   task automatic check(input string name, input int d, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", name, d, edge_n, act, exp);
      end
   endtask

   // Reference model: transaction-level prediction of every grant.
   initial begin
      for (int d = 0; d < 2; d++) begin
         rr_m[d] = 0; free_m[d] = 0; gedge_m[d] = -1000; gid_m[d] = 0;
      end
      forever begin
         @(posedge clk);
         edge_n++;
         for (int d = 0; d < 2; d++) begin
            if (rst) begin
               sb[d].delete();
               rr_m[d] = 0; free_m[d] = 0; gedge_m[d] = -1000; gid_m[d] = 0;
            end else if (edge_n >= free_m[d] && req_v[d] != '0) begin
               int w;
               exp_t e;
               w = -1;
               for (int k = 0; k < N; k++) begin
                  int j;
                  j = (rr_m[d] + k) % N;
                  if (w < 0 && req_v[d][j]) w = j;
               end
               e.id   = w;
               e.data = din_v[d][w*W +: W];
               e.when = edge_n + dly(d);
               sb[d].push_back(e);
               rr_m[d]    = (w + 1) % N;
               free_m[d]  = edge_n + dly(d) + 2;
               gedge_m[d] = edge_n;
               gid_m[d]   = w;
            end
         end
      end
   end

   // Monitor: compares DUT outputs against the scoreboard on the falling edge.
   initial begin
      last_m[0] = '0; last_m[1] = '0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (rst) begin
               check("reset_outputs", d,
                     64'({ack_w[d], ov_w[d], busy_w[d], gid_w[d], dout_w[d]}), 64'd0);
               last_m[d] = '0;
            end else begin
               if (ov_w[d]) begin
                  if (sb[d].size() == 0) begin
                     check("unexpected_delivery", d, 64'd1, 64'd0);
                  end else begin
                     exp_t e;
                     e = sb[d].pop_front();
                     check("ack_onehot", d, 64'(ack_w[d]), 64'(1) << e.id);
                     check("data_out", d, 64'(dout_w[d]), 64'(e.data));
                     check("delivery_edge", d, 64'(edge_n), 64'(e.when));
                     last_m[d] = e.data;
                  end
               end else begin
                  check("ack_idle", d, 64'(ack_w[d]), 64'd0);
                  check("data_hold", d, 64'(dout_w[d]), 64'(last_m[d]));
                  if (sb[d].size() != 0 && sb[d][0].when < edge_n) begin
                     check("missing_delivery", d, 64'(edge_n), 64'(sb[d][0].when));
                     void'(sb[d].pop_front());
                  end
               end
               check("busy", d, 64'(busy_w[d]),
                     64'((edge_n >= gedge_m[d]) && (edge_n <= gedge_m[d] + dly(d))));
               check("grant_id", d, 64'(gid_w[d]), 64'(gid_m[d]));
            end
         end
      end
   end

   // Requester behaviour: hold until ack, then drop or present a new flit.
   initial begin
      req_v[0] = '0; req_v[1] = '0; din_v[0] = '0; din_v[1] = '0;
      forever begin
         @(posedge clk);
         #2;
         for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
               if (ack_w[d][i]) begin
                  if (mask[i] && $urandom_range(99) < p_keep)
                     din_v[d][i*W +: W] = fixed ? 16'hABCD : 16'($urandom);
                  else
                     req_v[d][i] = 1'b0;
               end else if (!req_v[d][i] && mask[i] && $urandom_range(99) < p_raise) begin
                  req_v[d][i] = 1'b1;
                  din_v[d][i*W +: W] = fixed ? 16'hABCD : 16'($urandom);
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int t;
      mask = '0;
      t = 0;
      while ((req_v[0] != '0 || req_v[1] != '0) && t < 400) begin
         step(1);
         t++;
      end
      check("drain_req", 0, 64'(req_v[0]), 64'd0);
      check("drain_req", 1, 64'(req_v[1]), 64'd0);
      step(40);
      check("sb_empty", 0, 64'(sb[0].size()), 64'd0);
      check("sb_empty", 1, 64'(sb[1].size()), 64'd0);
   endtask

   initial begin
      step(3);
      rst = 1'b0;

      // single flit 0xABCD from requester 0
      fixed = 1'b1; mask = 4'b0001; p_raise = 100; p_keep = 0;
      step(50);
      drain();
      fixed = 1'b0;

      // all four requesting continuously
      mask = 4'b1111; p_raise = 100; p_keep = 100;
      step(200);
      drain();

      // requesters 0 and 2 continuously
      mask = 4'b0101; p_raise = 100; p_keep = 100;
      step(200);
      drain();

      // reset while requester 1's flit is in flight
      mask = 4'b0010; p_raise = 100; p_keep = 0;
      step(15);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(60);
      drain();

      // randomized traffic with occasional resets
      for (int r = 0; r < 40; r++) begin
         mask    = 4'($urandom);
         p_raise = $urandom_range(80, 5);
         p_keep  = $urandom_range(100, 0);
         step($urandom_range(120, 30));
         if ($urandom_range(9) == 0) begin
            rst = 1'b1;
            step(2);
            rst = 1'b0;
         end
      end
      drain();

      step(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
